rs232_tx_sched: RTL

Byte scheduler that shares one RS232 transmitter among N requesters. Picks one requester per frame by round-robin, drives the transmitter's `transmit_data`/`tx_vld` handshake, and watches `tx_rdy` to sequence frames. A requester can lock the transmitter for a multi-byte message with `req_last`. Sits between the client blocks (status reporter, debug console, etc.) and the RS232 transmitter instance.

---
 rtl/rs232_pkg.sv | 17 +
 rtl/rs232_rr_pick.sv | 33 +++
 rtl/rs232_tx_sched.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 transmit scheduler: FSM state encoding
// and the lost-frame detection window.
package rs232_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_LOCKED    = 3'd4
  } state_e;

  // Cycles tx_rdy may stay high (strobe cycle included) before the frame
  // is considered lost and the strobe is repeated.
  localparam int WAIT_BUSY_MAX = 4;

endpackage

// File: rtl/rs232_rr_pick.sv
// Combinational round-robin picker: starting just after ptr and wrapping
// modulo N, the first asserted request wins.
module rs232_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win,
  output logic [$clog2(N)-1:0] win_idx,
  output logic                 any
);

  localparam int PW = $clog2(N);

  int cand;

  // Scan ptr+1, ptr+2, ... ptr+N (mod N); the last candidate is ptr itself.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any     = 1'b1;
        win     = N'(1) << cand;
        win_idx = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/rs232_tx_sched.sv
// Shares one RS232 transmitter among N requesters. Arbitration is
// round-robin per message; a requester keeps the transmitter across bytes
// until it presents a byte flagged last, or until it idles for LOCK_TO
// cycles while holding the lock.
module rs232_tx_sched
  import rs232_pkg::*;
#(
  parameter int N       = 4,
  parameter int LOCK_TO = 1024
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req_vld,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ack,
  output logic [N-1:0]   grant,
  output logic [7:0]     transmit_data,
  output logic           tx_vld,
  input  logic           tx_rdy,
  output logic           busy,
  output logic           lock_err
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(LOCK_TO);
  localparam int BW = $clog2(WAIT_BUSY_MAX);

  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_TO - 1);
  // The strobe cycle already counts as one cycle of tx_rdy high, so the
  // wait state only needs WAIT_BUSY_MAX-1 more.
  localparam logic [BW-1:0] WB_LAST  = BW'(WAIT_BUSY_MAX - 2);

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] owner_q;
  logic [N-1:0]  grant_q;
  logic [7:0]    byte_p1;
  logic          last_p1;
  logic          retry_q;
  logic [BW-1:0] wb_cnt_q;
  logic [CW-1:0] lock_cnt_q;
  logic          lock_err_q;

  logic [7:0]    req_byte [N];
  logic [N-1:0]  pick_win;
  logic [PW-1:0] pick_idx;
  logic          pick_any;

  logic          pick_en;
  logic          relatch_en;
  logic          grant_clr;
  logic          retry_set;
  logic          lock_hit;

  // Lock idle counter holds at its maximum instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign req_byte[g] = req_data[8*g +: 8];
  end

  rs232_rr_pick #(
    .N (N)
  ) u_pick (
    .req     (req_vld),
    .ptr     (ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and the one-shot control strobes for the datapath.
  always_comb begin
    state_d    = state_q;
    pick_en    = 1'b0;
    relatch_en = 1'b0;
    grant_clr  = 1'b0;
    retry_set  = 1'b0;
    lock_hit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_rdy && pick_any) begin
          pick_en = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!tx_rdy) begin
          state_d = ST_WAIT_DONE;
        end else if (wb_cnt_q == WB_LAST) begin
          // Frame lost: strobe once more; if that is lost too, move on.
          if (!retry_q) begin
            retry_set = 1'b1;
            state_d   = ST_SEND;
          end else begin
            state_d   = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (tx_rdy) begin
          if (last_p1) begin
            grant_clr = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d   = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (req_vld[owner_q]) begin
          relatch_en = 1'b1;
          state_d    = ST_SEND;
        end else if (lock_cnt_q == LOCK_MAX) begin
          lock_hit  = 1'b1;
          grant_clr = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        grant_clr = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Ownership, round-robin pointer and the latched byte stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q   <= PW'(N - 1);
      owner_q <= '0;
      grant_q <= '0;
      byte_p1 <= '0;
      last_p1 <= 1'b0;
      retry_q <= 1'b0;
    end else begin
      if (pick_en) begin
        ptr_q   <= pick_idx;
        owner_q <= pick_idx;
        grant_q <= pick_win;
        byte_p1 <= req_byte[pick_idx];
        last_p1 <= req_last[pick_idx];
        retry_q <= 1'b0;
      end else if (relatch_en) begin
        byte_p1 <= req_byte[owner_q];
        last_p1 <= req_last[owner_q];
        retry_q <= 1'b0;
      end else if (retry_set) begin
        retry_q <= 1'b1;
      end
      if (grant_clr) begin
        grant_q <= '0;
      end
    end
  end

  // Lost-frame window: cycles spent in ST_WAIT_BUSY with tx_rdy still high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_cnt_q <= '0;
    end else if (state_q == ST_SEND) begin
      wb_cnt_q <= '0;
    end else if (state_q == ST_WAIT_BUSY && tx_rdy && wb_cnt_q != WB_LAST) begin
      wb_cnt_q <= wb_cnt_q + BW'(1);
    end
  end

  // Lock idle timer: runs only while locked and waiting for the owner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      lock_err_q <= lock_hit;
      if (state_q == ST_LOCKED && !relatch_en) begin
        lock_cnt_q <= sat_inc(lock_cnt_q);
      end else begin
        lock_cnt_q <= '0;
      end
    end
  end

  // A repeated strobe after a lost frame carries no second acknowledge.
  assign tx_vld        = (state_q == ST_SEND);
  assign req_ack       = (state_q == ST_SEND && !retry_q) ? grant_q : '0;
  assign grant         = grant_q;
  assign transmit_data = byte_p1;
  assign busy          = (state_q != ST_IDLE);
  assign lock_err      = lock_err_q;

endmodule
